// File: rtl/instr_rom_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_rom_monitor_if
// Brief    : Bus bundle between the CPU-level bench / core and the
//            instruction ROM monitor: program load port, fetch port,
//            $v0 observation and run-result flags.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_rom_monitor_if #(
    parameter int DEPTH = 64
);
    localparam int IDX_W = $clog2(DEPTH);

    // Program load port
    logic             load_en;
    logic [IDX_W-1:0] load_index;
    logic [31:0]      load_data;

    // Run control
    logic             start;

    // Fetch port towards the CPU
    logic [31:0]      instr_address;
    logic [31:0]      instr_readdata;

    // End-of-program check
    logic [31:0]      register_v0;
    logic [31:0]      expected_v0;

    // Run result
    logic             done;
    logic             pass;
    logic             timeout;
    logic             bad_fetch;
    logic [31:0]      cycle_count;

    // Bench / CPU side
    modport master (
        output load_en, load_index, load_data, start,
               instr_address, register_v0, expected_v0,
        input  instr_readdata, done, pass, timeout, bad_fetch, cycle_count
    );

    // Monitor side
    modport slave (
        input  load_en, load_index, load_data, start,
               instr_address, register_v0, expected_v0,
        output instr_readdata, done, pass, timeout, bad_fetch, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_rom_monitor.sv
`default_nettype none
// ============================================================================
// Module   : instr_rom_monitor
// Brief    : Loadable instruction ROM decoded at the reset vector, plus a
//            run-control FSM that detects program halt (fetch from
//            HALT_ADDR), checks $v0 against an expected value and enforces
//            a cycle-count timeout.
// Options  : IROM_FETCH_CHECK_EN - when defined, out-of-range or misaligned
//            fetches during a run raise a sticky bad_fetch flag and force a
//            failing result at halt. When undefined, bad_fetch is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module instr_rom_monitor #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          DEPTH        = 64,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000,
    parameter int          TIMEOUT      = 256
) (
    input  logic                clk,
    input  logic                reset,       // asynchronous, active low
    input  logic                clk_enable,
    instr_rom_monitor_if.slave  bus
);

    localparam int          IDX_W          = $clog2(DEPTH);
    localparam logic [31:0] c_ROM_BYTES    = 32'(DEPTH) << 2;
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] c_TIMEOUT_CNT  = 32'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_LOAD      = 2'd0,
        ST_RUN       = 2'd1,
        ST_HALTED    = 2'd2,
        ST_TIMED_OUT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Program store. Deliberately outside the reset domain so a reset in
    // the middle of a run keeps the loaded program.
    // ------------------------------------------------------------------
    logic [31:0] r_rom [DEPTH];

    // Write port: any state, only on enabled edges
    always_ff @(posedge clk) begin
        if (clk_enable && bus.load_en) begin
            r_rom[bus.load_index] <= bus.load_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch decode. The offset is taken modulo 2^32, so addresses below
    // the reset vector wrap to huge offsets and fall out of range on the
    // single unsigned compare.
    // ------------------------------------------------------------------
    logic [31:0]      w_offset;
    logic             w_in_range;
    logic [IDX_W-1:0] w_rom_index;
    logic             w_is_halt;

    assign w_offset    = bus.instr_address - RESET_VECTOR;
    assign w_in_range  = (w_offset < c_ROM_BYTES) && (w_offset[1:0] == 2'b00);
    assign w_rom_index = w_offset[IDX_W+1:2];
    assign w_is_halt   = (bus.instr_address == HALT_ADDR);

    // Combinational read; unmapped or misaligned fetches return a NOP
    always_comb begin
        bus.instr_readdata = 32'h0000_0000;
        if (w_in_range) begin
            bus.instr_readdata = r_rom[w_rom_index];
        end
    end

    // ------------------------------------------------------------------
    // Run-control state
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_pass;
    logic        w_pass_nxt;
    logic        r_timeout;
    logic        w_timeout_nxt;
    logic [31:0] r_cycle_count;
    logic [31:0] w_cycle_count_nxt;
    logic        w_bad_flag;     // current sticky bad-fetch status

    // ------------------------------------------------------------------
    // Optional fetch checker
    // ------------------------------------------------------------------
`ifdef IROM_FETCH_CHECK_EN
    logic r_bad_fetch;
    logic w_bad_fetch_nxt;

    // Sticky flag: cleared when a run is (re)started, set by any stray
    // fetch seen while running. The halt fetch itself never counts.
    always_comb begin
        w_bad_fetch_nxt = r_bad_fetch;
        if ((r_state != ST_RUN) && bus.start) begin
            w_bad_fetch_nxt = 1'b0;
        end else if ((r_state == ST_RUN) && !w_is_halt && !w_in_range) begin
            w_bad_fetch_nxt = 1'b1;
        end
    end

    // Bad-fetch register, gated like all other state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bad_fetch <= 1'b0;
        end else if (clk_enable) begin
            r_bad_fetch <= w_bad_fetch_nxt;
        end
    end

    assign w_bad_flag = r_bad_fetch;
`else
    assign w_bad_flag = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and result logic. Halt is tested before the timeout
    // limit so that a halt on the last allowed cycle still reports a
    // normal completion. The counter only moves in RUN, so it is frozen
    // everywhere else and saturates at TIMEOUT.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_done_nxt        = r_done;
        w_pass_nxt        = r_pass;
        w_timeout_nxt     = r_timeout;
        w_cycle_count_nxt = r_cycle_count;

        case (r_state)
            ST_LOAD, ST_HALTED, ST_TIMED_OUT: begin
                if (bus.start) begin
                    w_state_nxt       = ST_RUN;
                    w_done_nxt        = 1'b0;
                    w_pass_nxt        = 1'b0;
                    w_timeout_nxt     = 1'b0;
                    w_cycle_count_nxt = 32'd0;
                end
            end

            ST_RUN: begin
                if (w_is_halt) begin
                    w_state_nxt = ST_HALTED;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (bus.register_v0 == bus.expected_v0)
                                  && !w_bad_flag;
                end else if (r_cycle_count == c_TIMEOUT_LAST) begin
                    w_state_nxt       = ST_TIMED_OUT;
                    w_done_nxt        = 1'b1;
                    w_timeout_nxt     = 1'b1;
                    w_pass_nxt        = 1'b0;
                    w_cycle_count_nxt = c_TIMEOUT_CNT;
                end else begin
                    w_cycle_count_nxt = r_cycle_count + 32'd1;
                end
            end

            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // State and result registers; clk_enable low freezes everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_LOAD;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= 32'd0;
        end else if (clk_enable) begin
            r_state       <= w_state_nxt;
            r_done        <= w_done_nxt;
            r_pass        <= w_pass_nxt;
            r_timeout     <= w_timeout_nxt;
            r_cycle_count <= w_cycle_count_nxt;
        end
    end

    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.timeout     = r_timeout;
    assign bus.bad_fetch   = w_bad_flag;
    assign bus.cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: doc/instr_rom_monitor.md
# instr_rom_monitor

Parametrised instruction ROM and end-of-program checker for CPU-level test benches of the Harvard MIPS core. It replaces per-test hard-coded address-decode instruction blocks and free-running negedge asserts with a loadable program store. The store is decoded at the reset vector. A run-control FSM detects program halt (fetch from `HALT_ADDR`), compares `register_v0` against an expected value, and enforces a cycle-count timeout. It sits beside `mips_cpu_harvard` and `data_memory`, driving `instr_readdata` and reporting pass/fail to the bench.

## Interface
- `RESET_VECTOR`, 32'hBFC00000, byte address of ROM word 0
- `DEPTH`, 64, ROM size in 32-bit words (power of two, ≥2)
- `HALT_ADDR`, 32'h00000000, fetch address that signals program end
- `TIMEOUT`, 256, max enabled cycles in RUN before timeout (≥1)
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `clk_enable`  in  1  gates every sequential update, including loads
- `load_en`  in  1  write `load_data` to ROM word `load_index`
- `load_index`  in  $clog2(DEPTH)  ROM word index
- `load_data`  in  32  program word
- `start`  in  1  begin/restart run
- `instr_address`  in  32  CPU fetch address
- `instr_readdata`  out  32  fetched instruction
- `register_v0`  in  32  CPU $v0 debug output
- `expected_v0`  in  32  value required at halt
- `done`  out  1  run finished (halt or timeout), sticky
- `pass`  out  1  halted with `register_v0 == expected_v0`, sticky
- `timeout`  out  1  TIMEOUT reached without halt, sticky
- `bad_fetch`  out  1  out-of-range/misaligned fetch seen in RUN (see Configuration)
- `cycle_count`  out  32  enabled cycles elapsed in current run

## Operation
- FSM states: LOAD (reset state), RUN, HALTED, TIMED_OUT.
- LOAD → RUN on `start`. HALTED/TIMED_OUT → RUN on `start`. That transition clears `done`, `pass`, `timeout`, `bad_fetch`, and `cycle_count`. ROM is kept.
- `start` while in RUN is ignored.
- RUN, each enabled cycle:
  - If `instr_address == HALT_ADDR`: → HALTED, `done`=1, `pass` = (`register_v0 == expected_v0`), `cycle_count` not incremented.
  - Else if `cycle_count == TIMEOUT-1`: → TIMED_OUT, `done`=1, `timeout`=1, `pass`=0, `cycle_count`=TIMEOUT.
  - Else `cycle_count` += 1.
- Halt and timeout condition in the same cycle: halt wins.
- `cycle_count` is frozen outside RUN and never exceeds TIMEOUT.
- ROM writes are accepted in any state when `load_en`=1.
- Read decode is combinational:
  - In-range: `instr_address` in [RESET_VECTOR, RESET_VECTOR+4·DEPTH) and `instr_address[1:0]==0`.
  - In-range fetch returns `rom[(instr_address-RESET_VECTOR)>>2]`.
  - Any other address returns 32'h00000000 (NOP).
- Write-then-read of the same word: a read in the write cycle returns the old word; the new word is visible after the edge.

## Timing
- Reset values: FSM=LOAD, `done`=0, `pass`=0, `timeout`=0, `bad_fetch`=0, `cycle_count`=0.
- Reset does not clear ROM contents. A reset mid-run returns to LOAD and the program survives.
- `instr_readdata`: zero-cycle (combinational) from `instr_address` and ROM.
- Halt detection: `done`/`pass` asserted the rising edge after the cycle in which `HALT_ADDR` is presented.
- `register_v0` is sampled on that same edge.
- `start` → RUN on the next enabled edge. The first counted cycle is the one following.
- `clk_enable`=0: no state, counter, flag, or ROM change. Read path stays live.

## Configuration
- Macro `IROM_FETCH_CHECK_EN`.
- Defined: in RUN, any enabled cycle with an out-of-range or misaligned fetch that is not `HALT_ADDR` sets `bad_fetch`=1 (sticky). That run then reports `pass`=0 at halt regardless of $v0.
- Not defined: `bad_fetch` is tied to 0, no check logic is generated, and `pass` depends only on the $v0 compare.

## Test plan
- Load words 0–6 with the 7-word slt program (0x2484FFFF … 0x24000000), `expected_v0`=0, `start`. The bench steps `instr_address` from 0xBFC00000 by 4 and then presents 0x0 with `register_v0`=0. Required: `instr_readdata` matches each loaded word, then `done`=1, `pass`=1, `cycle_count`=7.
- Same sequence with `register_v0`=1 at halt → `done`=1, `pass`=0, `timeout`=0.
- `TIMEOUT`=16, hold `instr_address`=0xBFC00000 after `start` → after 16 enabled cycles `done`=1, `timeout`=1, `cycle_count`=16.
- Fetch 0xBFC00000+4·DEPTH and 0xBFC00002 → `instr_readdata`=0. With `IROM_FETCH_CHECK_EN`: `bad_fetch`=1 and `pass`=0 at a halt with matching $v0. Without the macro: `bad_fetch`=0.
- Assert `reset` low mid-run, release, `start` without reloading → ROM still returns the loaded words and the run passes.
- Drop `clk_enable` for 5 cycles mid-run → `cycle_count` unchanged across the gap and the halt result is unaffected.
